segre_history_buffer: RTL and testbench

Parametrised history buffer for precise exceptions. It records the previous value of each destination register at allocation, tracks completion and exception status from several writeback ports, and retires entries in order. When an exception reaches the oldest entry, it rolls the register file back youngest-first through a valid/ready port. It sits between decode (allocation) and the register file (rollback writes), with completion inputs driven by the execution pipes.

---
 rtl/segre_history_buffer.sv | 155 +++++++++++++++
 tb/tb_segre_history_buffer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/segre_history_buffer.sv
// In-order history buffer: records old register values at allocation, retires completed heads, and on an
// excepting head rolls the register file back youngest-first; rollback pauses while rb_ready_i is low.
module segre_history_buffer #(
    parameter int DEPTH    = 16,
    parameter int TAG_W    = $clog2(DEPTH),
    parameter int NUM_CMPL = 2,
    parameter int REG_W    = 5,
    parameter int DATA_W   = 32
) (
    input  logic                       clk_i,
    input  logic                       rsn_i,
    input  logic                       alloc_valid_i,
    output logic                       alloc_ready_o,
    input  logic [REG_W-1:0]           alloc_dest_reg_i,
    input  logic [DATA_W-1:0]          alloc_old_value_i,
    output logic [TAG_W-1:0]           alloc_tag_o,
    input  logic [NUM_CMPL-1:0]        cmpl_valid_i,
    input  logic [NUM_CMPL*TAG_W-1:0]  cmpl_tag_i,
    input  logic [NUM_CMPL-1:0]        cmpl_exc_i,
    output logic                       retire_valid_o,
    output logic [TAG_W-1:0]           retire_tag_o,
    output logic                       rb_valid_o,
    input  logic                       rb_ready_i,
    output logic [REG_W-1:0]           rb_reg_o,
    output logic [DATA_W-1:0]          rb_value_o,
    output logic                       recovering_o,
    output logic                       recover_done_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [TAG_W:0]             count_o,
    output logic                       err_o
);

    typedef enum logic [1:0] {ST_FREE, ST_EXEC, ST_DONE, ST_EXC} status_e;
    typedef enum logic {NORMAL, ROLLBACK} state_e;

    localparam logic [TAG_W:0]   FULL_CNT = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W:0]   ONE_CNT  = (TAG_W+1)'(1);
    localparam logic [TAG_W-1:0] ONE_TAG  = TAG_W'(1);

    state_e            state_q, state_d;
    logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [TAG_W:0]    count_q, count_d;
    status_e           status_q [DEPTH];
    status_e           status_d [DEPTH];
    logic [REG_W-1:0]  dest_q   [DEPTH];
    logic [DATA_W-1:0] value_q  [DEPTH];
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic [TAG_W-1:0]  rb_ptr;
    logic [TAG_W-1:0]  ctag;
    logic              alloc_fire, retire_fire, rb_fire;

    assign rb_ptr         = tail_q - ONE_TAG;
    assign empty_o        = (count_q == '0);
    assign full_o         = (count_q == FULL_CNT);
    assign alloc_ready_o  = (state_q == NORMAL) && !full_o;
    assign alloc_tag_o    = tail_q;
    assign count_o        = count_q;
    assign retire_valid_o = (state_q == NORMAL) && !empty_o && (status_q[head_q] == ST_DONE);
    assign retire_tag_o   = head_q;
    assign rb_valid_o     = (state_q == ROLLBACK);
    assign recovering_o   = (state_q == ROLLBACK);
    assign rb_reg_o       = dest_q[rb_ptr];
    assign rb_value_o     = value_q[rb_ptr];
    assign recover_done_o = done_q;
    assign err_o          = err_q;

    assign alloc_fire  = alloc_valid_i && alloc_ready_o;
    assign retire_fire = retire_valid_o;
    assign rb_fire     = rb_valid_o && rb_ready_i;

    always_comb begin
        status_d = status_q;
        state_d  = state_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        err_d    = err_q;
        done_d   = 1'b0;
        ctag     = '0;
        if (state_q == ROLLBACK) begin
            if (rb_fire) begin
                status_d[rb_ptr] = ST_FREE;
                tail_d           = rb_ptr;
                count_d          = count_q - ONE_CNT;
                if (count_q == ONE_CNT) begin
                    state_d = NORMAL;
                    done_d  = 1'b1;
                end
            end
        end else begin
            // Legality is judged on registered status so same-tag ports never flag each other.
            for (int p = 0; p < NUM_CMPL; p++) begin
                if (cmpl_valid_i[p]) begin
                    ctag = cmpl_tag_i[p*TAG_W +: TAG_W];
                    if (status_q[ctag] != ST_EXEC) begin
                        err_d = 1'b1;
                    end else if (cmpl_exc_i[p]) begin
                        status_d[ctag] = ST_EXC;
                    end else if (status_d[ctag] != ST_EXC) begin
                        status_d[ctag] = ST_DONE;
                    end
                end
            end
            if (retire_fire) begin
                status_d[head_q] = ST_FREE;
                head_d           = head_q + ONE_TAG;
            end
            if (alloc_fire) begin
                status_d[tail_q] = ST_EXEC;
                tail_d           = tail_q + ONE_TAG;
            end
            case ({alloc_fire, retire_fire})
                2'b10:   count_d = count_q + ONE_CNT;
                2'b01:   count_d = count_q - ONE_CNT;
                default: count_d = count_q;
            endcase
            // Looking at next-state status lets an excepting head start rollback one cycle after completion.
            if ((count_d != '0) && (status_d[head_d] == ST_EXC)) begin
                state_d = ROLLBACK;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rsn_i) begin
        if (rsn_i) begin
            state_q <= NORMAL;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                status_q[i] <= ST_FREE;
            end
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            err_q    <= err_d;
            done_q   <= done_d;
            status_q <= status_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (alloc_fire) begin
            dest_q[tail_q]  <= alloc_dest_reg_i;
            value_q[tail_q] <= alloc_old_value_i;
        end
    end

endmodule

// File: tb/tb_segre_history_buffer.sv
// Directed test-plan scenarios plus randomized traffic against a queue-based reference model.
module tb_segre_history_buffer;

    localparam int DEPTH  = 4;
    localparam int TAG_W  = 2;
    localparam int NCMPL  = 2;
    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int S_EXEC = 1;
    localparam int S_DONE = 2;
    localparam int S_EXC  = 3;

    logic                    clk = 1'b0;
    logic                    rsn = 1'b1;
    logic                    alloc_valid_i = 1'b0;
    logic                    alloc_ready_o;
    logic [REG_W-1:0]        alloc_dest_reg_i = '0;
    logic [DATA_W-1:0]       alloc_old_value_i = '0;
    logic [TAG_W-1:0]        alloc_tag_o;
    logic [NCMPL-1:0]        cmpl_valid_i = '0;
    logic [NCMPL*TAG_W-1:0]  cmpl_tag_i = '0;
    logic [NCMPL-1:0]        cmpl_exc_i = '0;
    logic                    retire_valid_o;
    logic [TAG_W-1:0]        retire_tag_o;
    logic                    rb_valid_o;
    logic                    rb_ready_i = 1'b0;
    logic [REG_W-1:0]        rb_reg_o;
    logic [DATA_W-1:0]       rb_value_o;
    logic                    recovering_o, recover_done_o, empty_o, full_o, err_o;
    logic [TAG_W:0]          count_o;

    always #5 clk = ~clk;

    segre_history_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_CMPL(NCMPL), .REG_W(REG_W), .DATA_W(DATA_W)) dut (
        .clk_i(clk), .rsn_i(rsn),
        .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
        .alloc_dest_reg_i(alloc_dest_reg_i), .alloc_old_value_i(alloc_old_value_i), .alloc_tag_o(alloc_tag_o),
        .cmpl_valid_i(cmpl_valid_i), .cmpl_tag_i(cmpl_tag_i), .cmpl_exc_i(cmpl_exc_i),
        .retire_valid_o(retire_valid_o), .retire_tag_o(retire_tag_o),
        .rb_valid_o(rb_valid_o), .rb_ready_i(rb_ready_i), .rb_reg_o(rb_reg_o), .rb_value_o(rb_value_o),
        .recovering_o(recovering_o), .recover_done_o(recover_done_o),
        .empty_o(empty_o), .full_o(full_o), .count_o(count_o), .err_o(err_o)
    );

    // Reference model: in-flight entries oldest-first in a queue.
    typedef struct {
        logic [REG_W-1:0]  r;
        logic [DATA_W-1:0] v;
        int                st;
    } ent_t;

    ent_t q[$];
    int   head_tag;
    bit   m_rb, m_rd, m_err;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        int sz;
        bit rv;
        sz = q.size();
        rv = !m_rb && (sz > 0) && (q[0].st == S_DONE);
        check("count", count_o, sz);
        check("empty", empty_o, sz == 0);
        check("full", full_o, sz == DEPTH);
        check("alloc_ready", alloc_ready_o, !m_rb && (sz < DEPTH));
        check("alloc_tag", alloc_tag_o, (head_tag + sz) % DEPTH);
        check("retire_valid", retire_valid_o, rv);
        if (rv) check("retire_tag", retire_tag_o, head_tag);
        check("rb_valid", rb_valid_o, m_rb);
        check("recovering", recovering_o, m_rb);
        if (m_rb && sz > 0) begin
            check("rb_reg", rb_reg_o, q[sz-1].r);
            check("rb_value", rb_value_o, q[sz-1].v);
        end
        check("recover_done", recover_done_o, m_rd);
        check("err", err_o, m_err);
    endtask

    // Drive one cycle of inputs (caller is at a negedge), advance the model, then compare at the next negedge.
    task automatic step(input bit av, input logic [REG_W-1:0] r, input logic [DATA_W-1:0] v,
                        input logic [1:0] cv, input logic [TAG_W-1:0] t0, input logic [TAG_W-1:0] t1,
                        input logic [1:0] ce, input bit rr);
        int newst[DEPTH];
        int idx;
        bit ret, afire;
        logic [TAG_W-1:0] tg;
        ent_t e;
        alloc_valid_i     = av;
        alloc_dest_reg_i  = r;
        alloc_old_value_i = v;
        cmpl_valid_i      = cv;
        cmpl_tag_i        = {t1, t0};
        cmpl_exc_i        = ce;
        rb_ready_i        = rr;
        ret   = !m_rb && (q.size() > 0) && (q[0].st == S_DONE);
        afire = av && !m_rb && (q.size() < DEPTH);
        m_rd  = 1'b0;
        if (m_rb) begin
            if (rr) begin
                void'(q.pop_back());
                if (q.size() == 0) begin
                    m_rb = 1'b0;
                    m_rd = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) newst[i] = 0;
            for (int p = 0; p < NCMPL; p++) begin
                if (cv[p]) begin
                    tg  = (p == 0) ? t0 : t1;
                    idx = (int'(tg) - head_tag + DEPTH) % DEPTH;
                    if (idx < q.size() && q[idx].st == S_EXEC) begin
                        if (ce[p]) newst[idx] = S_EXC;
                        else if (newst[idx] != S_EXC) newst[idx] = S_DONE;
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
            for (int i = 0; i < q.size(); i++) if (newst[i] != 0) q[i].st = newst[i];
            if (ret) begin
                void'(q.pop_front());
                head_tag = (head_tag + 1) % DEPTH;
            end
            if (afire) begin
                e.r = r; e.v = v; e.st = S_EXEC;
                q.push_back(e);
            end
            if (q.size() > 0 && q[0].st == S_EXC) m_rb = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input bit rr);
        step(1'b0, '0, '0, 2'b00, '0, '0, 2'b00, rr);
    endtask

    task automatic alloc(input logic [REG_W-1:0] r, input logic [DATA_W-1:0] v);
        step(1'b1, r, v, 2'b00, '0, '0, 2'b00, 1'b0);
    endtask

    task automatic cmpl(input logic [TAG_W-1:0] t, input bit exc);
        step(1'b0, '0, '0, 2'b01, t, '0, {1'b0, exc}, 1'b0);
    endtask

    task automatic model_reset();
        q.delete();
        head_tag = 0;
        m_rb = 1'b0; m_rd = 1'b0; m_err = 1'b0;
    endtask

    task automatic do_reset();
        rsn = 1'b1;
        alloc_valid_i = 1'b0; cmpl_valid_i = '0; cmpl_exc_i = '0; rb_ready_i = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rsn = 1'b0;
        compare_all();
    endtask

    initial begin
        logic [1:0] cv, ce;
        logic [TAG_W-1:0] t0, t1;

        // Reset values
        do_reset();
        check("reset_ready", alloc_ready_o, 1);
        check("reset_tag", alloc_tag_o, 0);

        // Fill to DEPTH; a further request is refused
        for (int i = 0; i < DEPTH; i++) alloc(REG_W'(i), DATA_W'(i));
        check("fill_full", full_o, 1);
        check("fill_ready", alloc_ready_o, 0);
        check("fill_count", count_o, 4);
        alloc(5'd9, 32'h99);
        check("fill_extra_count", count_o, 4);

        // Out-of-order completion, in-order retire
        do_reset();
        for (int i = 0; i < 3; i++) alloc(REG_W'(i), DATA_W'(i));
        cmpl(2, 0);
        check("ooo_no_retire2", retire_valid_o, 0);
        cmpl(1, 0);
        check("ooo_no_retire1", retire_valid_o, 0);
        cmpl(0, 0);
        for (int i = 0; i < 3; i++) begin
            check("ooo_retire_valid", retire_valid_o, 1);
            check("ooo_retire_tag", retire_tag_o, i);
            idle(1'b0);
        end
        check("ooo_empty", empty_o, 1);

        // Wrap-around
        do_reset();
        for (int i = 0; i < 6; i++) begin
            check("wrap_tag", alloc_tag_o, i % DEPTH);
            alloc(REG_W'(i), DATA_W'(i));
            cmpl(TAG_W'(i % DEPTH), 0);
            idle(1'b0);
        end
        check("wrap_empty", empty_o, 1);
        check("wrap_not_full", full_o, 0);
        for (int i = 0; i < DEPTH; i++) alloc(REG_W'(i), DATA_W'(i));
        check("wrap_full", full_o, 1);
        check("wrap_full_count", count_o, 4);
        check("wrap_full_tag", alloc_tag_o, 2);

        // Exception on head with one stall cycle during rollback
        do_reset();
        alloc(5'd5, 32'h11);
        alloc(5'd6, 32'h22);
        alloc(5'd7, 32'h33);
        cmpl(0, 1);
        check("rb_recovering", recovering_o, 1);
        check("rb_first_reg", rb_reg_o, 7);
        check("rb_first_val", rb_value_o, 32'h33);
        idle(1'b1);
        check("rb_second_reg", rb_reg_o, 6);
        idle(1'b0);
        check("rb_stall_reg", rb_reg_o, 6);
        check("rb_stall_val", rb_value_o, 32'h22);
        idle(1'b1);
        check("rb_third_reg", rb_reg_o, 5);
        check("rb_third_val", rb_value_o, 32'h11);
        idle(1'b1);
        check("rb_done_pulse", recover_done_o, 1);
        check("rb_done_empty", empty_o, 1);
        check("rb_done_ready", alloc_ready_o, 1);
        idle(1'b0);
        check("rb_done_cleared", recover_done_o, 0);

        // Same-tag DONE and EXC in one cycle, then completion of a free tag
        do_reset();
        alloc(5'd1, 32'hA);
        alloc(5'd2, 32'hB);
        step(1'b0, '0, '0, 2'b11, 2'd0, 2'd0, 2'b10, 1'b0);
        check("dual_exc", recovering_o, 1);
        check("dual_no_err", err_o, 0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);
        cmpl(3, 0);
        check("free_err", err_o, 1);
        idle(1'b0);
        check("free_err_sticky", err_o, 1);

        // Reset in the middle of a rollback
        do_reset();
        for (int i = 0; i < 3; i++) alloc(REG_W'(i + 10), DATA_W'(i));
        cmpl(0, 1);
        idle(1'b1);
        check("mid_rb_count", count_o, 2);
        rsn = 1'b1;
        #1;
        check("arst_rb_valid", rb_valid_o, 0);
        check("arst_recovering", recovering_o, 0);
        check("arst_count", count_o, 0);
        check("arst_empty", empty_o, 1);
        check("arst_ready", alloc_ready_o, 1);
        check("arst_tag", alloc_tag_o, 0);
        model_reset();
        @(negedge clk);
        rsn = 1'b0;
        compare_all();
        alloc(5'd3, 32'h3);
        check("arst_next_count", count_o, 1);

        // Randomized traffic in several segments
        for (int seg = 0; seg < 4; seg++) begin
            do_reset();
            for (int c = 0; c < 400; c++) begin
                cv = '0; ce = '0; t0 = '0; t1 = '0;
                for (int p = 0; p < NCMPL; p++) begin
                    logic [TAG_W-1:0] tg;
                    if ($urandom_range(0, 99) < 35) begin
                        cv[p] = 1'b1;
                        if (q.size() > 0 && $urandom_range(0, 99) < 95)
                            tg = TAG_W'((head_tag + int'($urandom_range(0, q.size() - 1))) % DEPTH);
                        else
                            tg = TAG_W'($urandom_range(0, DEPTH - 1));
                        if (p == 0) t0 = tg; else t1 = tg;
                        ce[p] = ($urandom_range(0, 99) < 8);
                    end
                end
                step($urandom_range(0, 99) < 60, REG_W'($urandom), DATA_W'($urandom),
                     cv, t0, t1, ce, $urandom_range(0, 99) < 70);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
